// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe
//   Registered two-operand bitwise gate with a valid/ready stream interface.
//   A direct beat returns f(a, b, op) one cycle after acceptance. An
//   accumulate packet, opened by acc_en in IDLE, folds each beat through the
//   selected gate with the running result standing in for operand B. Only the
//   final value of the packet is emitted.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   a, b, op            operands and gate select (b unused while accumulating)
//   acc_en, in_last     open a packet (IDLE only) / final beat of a packet
//   out_valid/out_ready result handshake
//   y, y_zero, y_parity result and its registered zero / parity flags
//   beat_cnt            beats folded into y, saturating
module logic_gate_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_parity,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               y_zero_q, y_zero_d;
    logic               y_parity_q, y_parity_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [CNT_W-1:0]   cnt_inc;
    logic [WIDTH-1:0]   res;
    logic               load_y;

    function automatic logic [WIDTH-1:0] gate_f(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z,
        input logic [2:0]       sel
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'd0:    r = x & z;
            3'd1:    r = x | z;
            3'd2:    r = ~(x & z);
            3'd3:    r = ~(x | z);
            3'd4:    r = x ^ z;
            3'd5:    r = ~(x ^ z);
            3'd6:    r = ~x;
            default: r = ~z;
        endcase
        return r;
    endfunction

    // Ready only looks at the output slot so a held result back-pressures
    // every beat, including beats in the middle of a packet.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        y_zero_d    = y_zero_q;
        y_parity_d  = y_parity_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        load_y      = 1'b0;
        res         = '0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                IDLE: begin
                    res = gate_f(a, b, op);
                    if (acc_en && !in_last) begin
                        acc_d   = res;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        load_y     = 1'b1;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
                default: begin
                    res = gate_f(a, acc_q, op);
                    if (in_last) begin
                        load_y     = 1'b1;
                        beat_cnt_d = cnt_inc;
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        acc_d = res;
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end

        // A load in the same cycle as an output handshake wins, keeping
        // out_valid high with the fresh result.
        if (load_y) begin
            y_d         = res;
            y_zero_d    = (res == '0);
            y_parity_d  = ^res;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            y_zero_q    <= 1'b1;
            y_parity_q  <= 1'b0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            y_zero_q    <= y_zero_d;
            y_parity_q  <= y_parity_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign y_zero    = y_zero_q;
    assign y_parity  = y_parity_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe
//   Directed-vector bench for logic_gate_pipe (WIDTH=8, CNT_W=8) with
//   hand-computed expected values.
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_en;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       y_zero;
    logic       y_parity;
    logic [7:0] beat_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hF0};

    logic_gate_pipe #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_zero    (y_zero),
        .y_parity  (y_parity),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [2:0] top, input logic ten, input logic tlast);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        op       = top;
        acc_en   = ten;
        in_last  = tlast;
        step();
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        acc_en   = 1'b0;
        in_last  = 1'b0;
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        acc_en    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 8'h00);
        check("rst_y_zero", y_zero, 1);
        check("rst_y_parity", y_parity, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // Direct beats
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        check("and_valid", out_valid, 1);
        check("and_y", y, 8'h30);
        check("and_zero", y_zero, 0);
        check("and_parity", y_parity, 0);
        check("and_cnt", beat_cnt, 1);
        send(8'hFF, 8'h00, 3'd3, 1'b0, 1'b0);
        check("nor_y", y, 8'h00);
        check("nor_zero", y_zero, 1);
        send(8'h07, 8'h00, 3'd1, 1'b0, 1'b0);
        check("or7_y", y, 8'h07);
        check("or7_parity", y_parity, 1);
        check("or7_zero", y_zero, 0);
        idle_cycle();
        check("drain_valid", out_valid, 0);

        // All ops back-to-back
        for (int i = 0; i < 8; i++) begin
            send(8'hA5, 8'h0F, 3'(i), 1'b0, 1'b0);
            check($sformatf("sweep_y_op%0d", i), y, sweep_exp[i]);
            check($sformatf("sweep_valid_op%0d", i), out_valid, 1);
            check($sformatf("sweep_ready_op%0d", i), in_ready, 1);
        end
        idle_cycle();

        // XOR accumulate; b of later beats must be ignored
        send(8'h01, 8'h02, 3'd4, 1'b1, 1'b0);
        check("xacc_b1_valid", out_valid, 0);
        send(8'h04, 8'hFF, 3'd4, 1'b1, 1'b0);
        check("xacc_b2_valid", out_valid, 0);
        send(8'h08, 8'hFF, 3'd4, 1'b0, 1'b1);
        check("xacc_valid", out_valid, 1);
        check("xacc_y", y, 8'h0F);
        check("xacc_parity", y_parity, 0);
        check("xacc_cnt", beat_cnt, 3);
        idle_cycle();

        // Back-pressure with a new beat waiting
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 3'd0, 1'b0, 1'b0);
        check("bp_y", y, 8'h30);
        a  = 8'h0F;
        b  = 8'hFF;
        op = 3'd0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
            check($sformatf("bp_valid_%0d", i), out_valid, 1);
            check($sformatf("bp_y_%0d", i), y, 8'h30);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_new_valid", out_valid, 1);
        check("bp_new_y", y, 8'h0F);
        check("bp_new_cnt", beat_cnt, 1);
        idle_cycle();
        check("bp_drain_valid", out_valid, 0);

        // Reset mid-packet
        send(8'h11, 8'h22, 3'd1, 1'b1, 1'b0);
        send(8'h33, 8'h00, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", out_valid, 0);
        check("mrst_y", y, 8'h00);
        check("mrst_zero", y_zero, 1);
        check("mrst_cnt", beat_cnt, 0);
        send(8'h0F, 8'hF0, 3'd1, 1'b0, 1'b1);
        check("mrst_next_y", y, 8'hFF);
        check("mrst_next_cnt", beat_cnt, 1);
        check("mrst_next_valid", out_valid, 1);
        idle_cycle();

        // 300-beat OR packet, counter saturates at 255
        send(8'h01, 8'h80, 3'd1, 1'b1, 1'b0);
        for (int i = 0; i < 298; i++) begin
            send(8'h01, 8'h00, 3'd1, 1'b0, 1'b0);
        end
        check("sat_no_early_valid", out_valid, 0);
        send(8'h01, 8'h00, 3'd1, 1'b0, 1'b1);
        check("sat_valid", out_valid, 1);
        check("sat_y", y, 8'h81);
        check("sat_cnt", beat_cnt, 255);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
